// File: rtl/dup_range_pkg.sv
// Shared types for the repeating range generator and its range sub-generator.
package dup_range_pkg;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StCall,
        StEmit,
        StDrain
    } state_e;

    // Generator-style handshake bundle between caller and callee
    typedef struct packed {
        logic valid;
        logic ready;
        logic done;
    } hs_t;

endpackage

// File: rtl/hrange_gen.sv
// Range generator: yields base, base+step, ... while value < limit.
// Empty ranges (step <= 0 or base >= limit) raise done without yielding.
module hrange_gen #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] value
);

    logic signed [WIDTH-1:0] cur_q;
    logic signed [WIDTH-1:0] lim_q;
    logic signed [WIDTH-1:0] stp_q;
    logic                    active_q;
    logic                    done_q;
    logic signed [WIDTH:0]   next_val;
    logic signed [WIDTH:0]   lim_ext;
    logic                    start_empty;

    // One extra bit so stepping past the signed maximum ends the range instead of wrapping
    assign next_val    = $signed({cur_q[WIDTH-1], cur_q}) + $signed({stp_q[WIDTH-1], stp_q});
    assign lim_ext     = $signed({lim_q[WIDTH-1], lim_q});
    assign start_empty = step[WIDTH-1] || (step == '0) || (base >= limit);

    // Capture the range on start, advance on each accepted value
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            cur_q    <= '0;
            lim_q    <= '0;
            stp_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (_start) begin
            cur_q    <= base;
            lim_q    <= limit;
            stp_q    <= step;
            active_q <= !start_empty;
            done_q   <= start_empty;
        end else if (active_q && _ready) begin
            if (next_val < lim_ext) begin
                cur_q <= next_val[WIDTH-1:0];
            end else begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end
        end
    end

    assign _valid = active_q;
    assign _done  = done_q;
    assign value  = cur_q;

endmodule

// File: rtl/dup_range_repeat.sv
// Repeating range generator: every value from the range sub-generator is
// presented REPEAT times, tagged with its repetition index.
module dup_range_repeat
    import dup_range_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REPEAT = 2,
    parameter int IDX_W  = $clog2(REPEAT + 1)
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic [IDX_W-1:0]        _1
);

    if (REPEAT < 1) begin : g_bad_repeat
        $error("dup_range_repeat: REPEAT must be at least 1");
    end

    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(REPEAT - 2);

    state_e                  state_q;
    logic signed [WIDTH-1:0] base_q;
    logic signed [WIDTH-1:0] limit_q;
    logic signed [WIDTH-1:0] step_q;
    logic                    child_start_q;
    logic signed [WIDTH-1:0] value_q;
    logic [IDX_W-1:0]        cnt_q;
    logic                    valid_q;
    logic                    done_q;

    logic                    child_valid;
    logic                    child_done;
    logic                    child_ready;
    logic signed [WIDTH-1:0] child_value;
    hs_t                     child_hs;
    logic                    range_empty;

    // Child outputs are stale while its start pulse is in flight, so hold off the handshake
    assign child_ready = (state_q == StCall) && !child_start_q;
    assign child_hs    = '{valid: child_valid, ready: child_ready, done: child_done};

    // Decided from the latched range so an empty call finishes one cycle early
    assign range_empty = step_q[WIDTH-1] || (step_q == '0) || (base_q >= limit_q);

    hrange_gen #(
        .WIDTH (WIDTH)
    ) u_hrange (
        ._clock   (_clock),
        ._reset_n (_reset_n),
        ._start   (child_start_q),
        .base     (base_q),
        .limit    (limit_q),
        .step     (step_q),
        ._ready   (child_hs.ready),
        ._valid   (child_valid),
        ._done    (child_done),
        .value    (child_value)
    );

    // Sequencer FSM with registered outputs; _start overrides every state action
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q       <= StIdle;
            base_q        <= '0;
            limit_q       <= '0;
            step_q        <= '0;
            child_start_q <= 1'b0;
            value_q       <= '0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            child_start_q <= 1'b0;
            if (_start) begin
                base_q        <= base;
                limit_q       <= limit;
                step_q        <= step;
                child_start_q <= 1'b1;
                cnt_q         <= '0;
                valid_q       <= 1'b0;
                done_q        <= 1'b0;
                state_q       <= StCall;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    StCall: begin
                        if (child_start_q) begin
                            if (range_empty) begin
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else if (child_hs.valid) begin
                            value_q <= child_value;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= (REPEAT == 1) ? StDrain : StEmit;
                        end else if (child_hs.done) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StEmit: begin
                        if (_ready) begin
                            cnt_q <= cnt_q + IDX_W'(1);
                            if (cnt_q == PENULT_IDX) begin
                                state_q <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        if (_ready) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= StCall;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _0     = value_q;
    assign _1     = cnt_q;

endmodule

// File: tb/tb_dup_range_repeat.sv
// Bench for dup_range_repeat: a 32-bit REPEAT=2 instance and an 8-bit REPEAT=3
// instance share clock, reset, start and range inputs; each has its own ready.
module tb_dup_range_repeat;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               ready_a;
    logic               ready_b;

    logic               va;
    logic               da;
    logic signed [31:0] oa0;
    logic [1:0]         oa1;
    logic               vb;
    logic               db;
    logic signed [7:0]  ob0;
    logic [1:0]         ob1;

    int compared   = 0;
    int mismatched = 0;
    bit fin;

    longint exp_va[$];
    longint got_va[$];
    int     exp_ia[$];
    int     got_ia[$];
    longint exp_vb[$];
    longint got_vb[$];
    int     exp_ib[$];
    int     got_ib[$];

    always #5 clk = ~clk;

    dup_range_repeat #(
        .WIDTH  (32),
        .REPEAT (2)
    ) u_dut_a (
        ._clock   (clk),
        ._reset_n (rst_n),
        ._start   (start),
        .base     (base),
        .limit    (limit),
        .step     (step),
        ._ready   (ready_a),
        ._valid   (va),
        ._done    (da),
        ._0       (oa0),
        ._1       (oa1)
    );

    dup_range_repeat #(
        .WIDTH  (8),
        .REPEAT (3)
    ) u_dut_b (
        ._clock   (clk),
        ._reset_n (rst_n),
        ._start   (start),
        .base     (base[7:0]),
        .limit    (limit[7:0]),
        .step     (step[7:0]),
        ._ready   (ready_b),
        ._valid   (vb),
        ._done    (db),
        ._0       (ob0),
        ._1       (ob1)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint sx8(input longint x);
        logic signed [7:0] t;
        t = x[7:0];
        return longint'(t);
    endfunction

    // Reference: every range value in order, each repeated rep times with index 0..rep-1
    task automatic model(input longint b, input longint l, input longint s, input int rep,
                         input bit sel);
        for (longint v = b; s > 0 && v < l; v += s) begin
            for (int k = 0; k < rep; k++) begin
                if (sel) begin
                    exp_vb.push_back(v);
                    exp_ib.push_back(k);
                end else begin
                    exp_va.push_back(v);
                    exp_ia.push_back(k);
                end
            end
        end
    endtask

    // mode 0: always ready, 1: toggles 1-0-1, 2: random
    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !k[0];
        return ($urandom_range(3) != 0);
    endfunction

    task automatic run_seq(input longint b, input longint l, input longint s, input int mode);
        int  first_a = -1;
        int  first_b = -1;
        int  done_ka = -1;
        int  done_kb = -1;
        bit  hold_a  = 1'b0;
        bit  hold_b  = 1'b0;
        longint hv_a = 0;
        longint hv_b = 0;
        int  hi_a    = 0;
        int  hi_b    = 0;
        exp_va.delete(); got_va.delete(); exp_ia.delete(); got_ia.delete();
        exp_vb.delete(); got_vb.delete(); exp_ib.delete(); got_ib.delete();
        model(b, l, s, 2, 1'b0);
        model(sx8(b), sx8(l), sx8(s), 3, 1'b1);
        @(posedge clk); #1;
        base = 32'(b); limit = 32'(l); step = 32'(s);
        start = 1'b1; ready_a = rdy(mode, 0); ready_b = rdy(mode, 0);
        @(posedge clk); #1;
        start = 1'b0; ready_a = rdy(mode, 1); ready_b = rdy(mode, 1);
        fin = 1'b0;
        for (int k = 1; k <= 2000 && !fin; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                check("early_valid_a", va, 0);
                check("early_valid_b", vb, 0);
            end
            if (hold_a) begin
                check("hold_valid_a", va, 1);
                check("hold_val_a", oa0, hv_a);
                check("hold_idx_a", oa1, hi_a);
            end
            if (hold_b) begin
                check("hold_valid_b", vb, 1);
                check("hold_val_b", ob0, hv_b);
                check("hold_idx_b", ob1, hi_b);
            end
            hold_a = va && !ready_a; hv_a = longint'(oa0); hi_a = int'(oa1);
            hold_b = vb && !ready_b; hv_b = longint'(ob0); hi_b = int'(ob1);
            if (va && ready_a) begin got_va.push_back(longint'(oa0)); got_ia.push_back(int'(oa1)); end
            if (vb && ready_b) begin got_vb.push_back(longint'(ob0)); got_ib.push_back(int'(ob1)); end
            if (va && first_a < 0) first_a = k;
            if (vb && first_b < 0) first_b = k;
            if (da && done_ka < 0) done_ka = k;
            if (db && done_kb < 0) done_kb = k;
            fin = da && db;
            if (!fin) begin
                @(posedge clk); #1;
                ready_a = rdy(mode, k + 1);
                ready_b = rdy(mode, k + 1);
            end
        end
        check("finished", fin, 1);
        check("count_a", got_va.size(), exp_va.size());
        check("count_b", got_vb.size(), exp_vb.size());
        for (int i = 0; i < exp_va.size() && i < got_va.size(); i++) begin
            check("value_a", got_va[i], exp_va[i]);
            check("index_a", got_ia[i], exp_ia[i]);
        end
        for (int i = 0; i < exp_vb.size() && i < got_vb.size(); i++) begin
            check("value_b", got_vb[i], exp_vb[i]);
            check("index_b", got_ib[i], exp_ib[i]);
        end
        if (exp_va.size() > 0) check("latency_a", first_a, 3);
        else                   check("empty_done_a", done_ka, 2);
        if (exp_vb.size() > 0) check("latency_b", first_b, 3);
        else                   check("empty_done_b", done_kb, 2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; limit = '0; step = '0;
        ready_a = 1'b0; ready_b = 1'b0;
        #12;
        check("rst_valid_a", va, 0);
        check("rst_done_a", da, 0);
        check("rst_out0_a", oa0, 0);
        check("rst_out1_a", oa1, 0);
        check("rst_valid_b", vb, 0);
        check("rst_done_b", db, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("idle_done_a", da, 1);
        check("idle_done_b", db, 1);

        run_seq(0, 10, 2, 0);
        run_seq(5, 6, 1, 1);
        run_seq(3, 3, 1, 0);
        run_seq(0, 4, -1, 0);
        run_seq(120, 127, 5, 2);
        run_seq(100, 127, 20, 0);

        // Restart while the second copy of 4 is being held
        @(posedge clk); #1;
        base = 0; limit = 10; step = 2; start = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (va && oa0 == 4 && oa1 == 0) fin = 1'b1;
        end
        check("reach_four", fin, 1);
        @(posedge clk); #1;
        ready_a = 1'b0;
        @(negedge clk);
        check("second_copy_valid", va, 1);
        check("second_copy_val", oa0, 4);
        check("second_copy_idx", oa1, 1);
        run_seq(10, 13, 1, 0);

        // Asynchronous reset while a tuple is pending
        @(posedge clk); #1;
        base = 6; limit = 20; step = 3; start = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_valid", va, 1);
        check("pre_reset_val", oa0, 6);
        rst_n = 1'b0;
        #1;
        check("async_valid_a", va, 0);
        check("async_done_a", da, 0);
        check("async_out0_a", oa0, 0);
        check("async_out1_a", oa1, 0);
        check("async_valid_b", vb, 0);
        check("async_done_b", db, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_done_a", da, 1);
        check("post_reset_done_b", db, 1);
        check("post_reset_valid_a", va, 0);

        for (int r = 0; r < 8; r++) begin
            longint b;
            longint l;
            longint s;
            b = longint'($urandom_range(100)) - 50;
            l = b + longint'($urandom_range(45)) - 5;
            s = longint'($urandom_range(10)) - 2;
            run_seq(b, l, s, int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
